cube_frame_sequencer: RTL and testbench

//  Per-frame animation controller for the ray-marched cube renderer. It tracks the VGA raster,
//  and at the start of vertical blanking it steps the cube rotation angle and looks up sin/cos.
//  It then offers the new parameter set to the renderer over a valid/ready handshake.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/cube_trig_lut.sv | 51 +++++
 rtl/cube_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_cube_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and the frame sequencer state encoding.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    // Peak magnitude of the signed sin/cos outputs.
    localparam int SIN_AMP  = 127;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        TRIG    = 2'd2,
        OFFER   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cube_trig_lut.sv
// Signed 8-bit sine of an 8-bit angle (256 steps per turn) using a folded
// quarter-wave table, with a single registered output stage.
module cube_trig_lut
    import vga_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // round(127*sin(2*pi*i/256)) for i = 0..63.
    localparam logic [6:0] SIN_Q [0:63] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    logic [1:0] quad;
    logic [5:0] idx;
    logic [6:0] mag;
    logic [7:0] data_nxt;

    assign quad = addr[7:6];
    assign idx  = addr[5:0];

    // Odd quadrants run the table backwards; the peak sits one past its end.
    always_comb begin
        if (quad[0]) begin
            mag = (idx == 6'd0) ? 7'(SIN_AMP) : SIN_Q[6'(7'd64 - {1'b0, idx})];
        end else begin
            mag = SIN_Q[idx];
        end
        data_nxt = quad[1] ? 8'(-{1'b0, mag}) : {1'b0, mag};
    end

    // NOTE: the table is a constant ROM, so only the output register takes reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= data_nxt;
        end
    end

endmodule

// File: rtl/cube_frame_sequencer.sv
// Per-frame cube rotation controller: steps the angle at vblank, looks up
// sin/cos, and commits the new set only when the renderer accepts it.
module cube_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        h_count,
    input  logic [9:0]         v_count,
    input  logic               pause,
    input  logic               dir,
    input  logic [SPEED_W-1:0] speed,
    input  logic               overrun_clr,
    output logic               param_valid,
    input  logic               param_ready,
    output logic [7:0]         angle,
    output logic [7:0]         sin_a,
    output logic [7:0]         cos_a,
    output logic [7:0]         frame_cnt,
    output logic               overrun
);

    seq_state_t state, state_nxt;
    logic [1:0] trig_cnt;
    logic [7:0] next_angle, next_sin, next_cos;
    logic [7:0] lut_addr, lut_data, step;
    logic       frame_start, deadline;
    logic       load_angle, cap_sin, cap_cos, commit, set_overrun;

    assign frame_start = (v_count == 10'(V_ACTIVE)) && (h_count == 11'd0);
    assign deadline    = (v_count == 10'(V_TOTAL - 1)) && (h_count == 11'(H_TOTAL - 1));
    assign step        = 8'(speed);

    cube_trig_lut u_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (lut_addr),
        .data (lut_data)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        param_valid = 1'b0;
        load_angle  = 1'b0;
        cap_sin     = 1'b0;
        cap_cos     = 1'b0;
        commit      = 1'b0;
        set_overrun = 1'b0;
        lut_addr    = next_angle;
        case (state)
            IDLE: begin
                if (frame_start && !pause) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                load_angle = 1'b1;
                state_nxt  = TRIG;
            end
            TRIG: begin
                if (trig_cnt == 2'd1) begin
                    cap_sin  = 1'b1;
                    lut_addr = next_angle + 8'd64;
                end
                if (trig_cnt == 2'd2) begin
                    cap_cos   = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                param_valid = 1'b1;
                // Acceptance outranks a coincident deadline.
                if (param_ready) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else if (deadline) begin
                    set_overrun = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            trig_cnt <= '0;
        end else begin
            state    <= state_nxt;
            trig_cnt <= (state == TRIG) ? trig_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_angle <= '0;
            next_sin   <= '0;
            next_cos   <= '0;
            angle      <= '0;
            sin_a      <= '0;
            cos_a      <= 8'(SIN_AMP);
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (load_angle) next_angle <= dir ? angle - step : angle + step;
            if (cap_sin)    next_sin   <= lut_data;
            if (cap_cos)    next_cos   <= lut_data;
            if (commit) begin
                angle     <= next_angle;
                sin_a     <= next_sin;
                cos_a     <= next_cos;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (set_overrun)      overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cube_frame_sequencer.sv
// Directed bench for cube_frame_sequencer; the raster is driven directly so
// each frame only takes a handful of cycles.
module tb_cube_frame_sequencer;
    import vga_timing_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        pause, dir, overrun_clr, param_ready;
    logic [3:0]  speed;
    logic        param_valid, overrun;
    logic [7:0]  angle, sin_a, cos_a, frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;
    int waited;
    logic seen_valid;

    always #5 clk = ~clk;

    cube_frame_sequencer #(.SPEED_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .h_count     (h_count),
        .v_count     (v_count),
        .pause       (pause),
        .dir         (dir),
        .speed       (speed),
        .overrun_clr (overrun_clr),
        .param_valid (param_valid),
        .param_ready (param_ready),
        .angle       (angle),
        .sin_a       (sin_a),
        .cos_a       (cos_a),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic raster(input int v, input int h);
        v_count = 10'(v);
        h_count = 11'(h);
    endtask

    // One cycle of frame_start; returns at the following falling edge.
    task automatic frame_start_pulse();
        raster(V_ACTIVE, 0);
        @(negedge clk);
        raster(V_ACTIVE, 1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (param_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 8'(param_valid), 8'd1);
    endtask

    task automatic check_set(input string tag, input logic [7:0] ea, input logic [7:0] es,
                             input logic [7:0] ec);
        check({tag, ".angle"}, angle, ea);
        check({tag, ".sin"},   sin_a, es);
        check({tag, ".cos"},   cos_a, ec);
        check({tag, ".fcnt"},  frame_cnt, 8'(exp_fc));
    endtask

    // Full frame with ready held high: offer, commit, then back to idle raster.
    task automatic run_frame(input string tag, input logic [3:0] spd, input logic d,
                             input logic [7:0] ea, input logic [7:0] es, input logic [7:0] ec);
        int n;
        speed = spd;
        dir = d;
        param_ready = 1'b1;
        frame_start_pulse();
        wait_valid({tag, ".valid"}, n);
        @(negedge clk);
        exp_fc++;
        check({tag, ".drop"}, 8'(param_valid), 8'd0);
        check_set(tag, ea, es, ec);
        raster(100, 5);
    endtask

    initial begin
        rst = 1'b1;
        raster(100, 5);
        pause = 1'b0; dir = 1'b0; speed = 4'd0; overrun_clr = 1'b0; param_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst.valid", 8'(param_valid), 8'd0);
        check("rst.ovr",   8'(overrun), 8'd0);
        check_set("rst", 8'd0, 8'd0, 8'd127);

        // Single frame with exact 6-cycle latency and a 1-cycle valid pulse
        speed = 4'd3; dir = 1'b0; param_ready = 1'b1;
        frame_start_pulse();
        repeat (3) @(negedge clk);
        check("t2.valid_early", 8'(param_valid), 8'd0);
        @(negedge clk);
        check("t2.valid_on", 8'(param_valid), 8'd1);
        check("t2.angle_old", angle, 8'd0);
        @(negedge clk);
        exp_fc = 1;
        check("t2.valid_off", 8'(param_valid), 8'd0);
        check_set("t2", 8'd3, 8'd9, 8'd127);
        raster(100, 5);

        // Ready high while idle must not disturb anything
        repeat (4) @(negedge clk);
        check("t2.idle_valid", 8'(param_valid), 8'd0);
        check_set("t2.idle", 8'd3, 8'd9, 8'd127);

        // Wrap-around both directions, walk to 64, speed 0, negative cosine
        run_frame("t3.dn",  4'd5,  1'b1, 8'd254, 8'(-6),  8'd127);
        run_frame("t3.up",  4'd5,  1'b0, 8'd3,   8'd9,    8'd127);
        run_frame("t3.dn2", 4'd5,  1'b1, 8'd254, 8'(-6),  8'd127);
        run_frame("t3.a8",  4'd10, 1'b0, 8'd8,   8'd25,   8'd125);
        run_frame("t3.a23", 4'd15, 1'b0, 8'd23,  8'd68,   8'd107);
        run_frame("t3.a38", 4'd15, 1'b0, 8'd38,  8'd102,  8'd76);
        run_frame("t3.a53", 4'd15, 1'b0, 8'd53,  8'd122,  8'd34);
        run_frame("t3.a64", 4'd11, 1'b0, 8'd64,  8'd127,  8'd0);
        run_frame("t3.s0",  4'd0,  1'b1, 8'd64,  8'd127,  8'd0);
        run_frame("t3.a79", 4'd15, 1'b0, 8'd79,  8'd118,  8'(-46));

        // Backpressure: 40 cycles of ready low, inputs changed meanwhile
        speed = 4'd4; dir = 1'b0; param_ready = 1'b0;
        frame_start_pulse();
        wait_valid("t4.valid", waited);
        speed = 4'd9; dir = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("t4.hold_valid", 8'(param_valid), 8'd1);
            check("t4.hold_angle", angle, 8'd79);
        end
        param_ready = 1'b1;
        @(negedge clk);
        exp_fc++;
        check("t4.drop", 8'(param_valid), 8'd0);
        check_set("t4", 8'd83, 8'd113, 8'(-57));
        raster(100, 5);

        // Deadline missed: no commit, overrun set
        speed = 4'd1; dir = 1'b0; param_ready = 1'b0;
        frame_start_pulse();
        wait_valid("t5.valid", waited);
        repeat (5) @(negedge clk);
        raster(V_TOTAL - 1, H_TOTAL - 1);
        @(negedge clk);
        raster(100, 5);
        check("t5.drop", 8'(param_valid), 8'd0);
        check("t5.ovr",  8'(overrun), 8'd1);
        check_set("t5", 8'd83, 8'd113, 8'(-57));
        repeat (3) @(negedge clk);
        check("t5.idle_valid", 8'(param_valid), 8'd0);

        run_frame("t5.next", 4'd1, 1'b0, 8'd84, 8'd112, 8'(-60));
        check("t5.ovr_sticky", 8'(overrun), 8'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t5.ovr_clr", 8'(overrun), 8'd0);

        // Ready and deadline on the same cycle: acceptance wins
        speed = 4'd2; dir = 1'b0; param_ready = 1'b0;
        frame_start_pulse();
        wait_valid("t5c.valid", waited);
        raster(V_TOTAL - 1, H_TOTAL - 1);
        param_ready = 1'b1;
        @(negedge clk);
        raster(100, 5);
        exp_fc++;
        check("t5c.drop", 8'(param_valid), 8'd0);
        check("t5c.ovr",  8'(overrun), 8'd0);
        check_set("t5c", 8'd86, 8'd109, 8'(-65));

        // New overrun and clear on the same cycle: set wins
        speed = 4'd3; param_ready = 1'b0;
        frame_start_pulse();
        wait_valid("t5s.valid", waited);
        raster(V_TOTAL - 1, H_TOTAL - 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        raster(100, 5);
        overrun_clr = 1'b0;
        check("t5s.ovr", 8'(overrun), 8'd1);
        check_set("t5s", 8'd86, 8'd109, 8'(-65));

        // Pause over three frames
        pause = 1'b1; speed = 4'd7; param_ready = 1'b1;
        seen_valid = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame_start_pulse();
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                seen_valid = seen_valid | param_valid;
            end
            raster(100, 5);
        end
        check("t6.pause_valid", 8'(seen_valid), 8'd0);
        check_set("t6.pause", 8'd86, 8'd109, 8'(-65));
        pause = 1'b0;

        // Reset while offering: immediate, between clock edges
        speed = 4'd7; param_ready = 1'b0;
        frame_start_pulse();
        wait_valid("t6r.valid", waited);
        #2 rst = 1'b1;
        #1;
        exp_fc = 0;
        check("t6r.valid_async", 8'(param_valid), 8'd0);
        check("t6r.ovr", 8'(overrun), 8'd0);
        check_set("t6r", 8'd0, 8'd0, 8'd127);
        @(negedge clk);
        rst = 1'b0;
        raster(100, 5);
        @(negedge clk);
        run_frame("t6r.restart", 4'd3, 1'b0, 8'd3, 8'd9, 8'd127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
